// File: rtl/in_port_2_pkg.sv
// Shared SAP-II I/O package.
// Holds the default serial word width and the bit layout of the input-port status byte.
package in_port_2_pkg;

    localparam int unsigned DataWDefault = 8;

    // Status byte layout for the default width. Wider words keep these flags at the top.
    localparam int unsigned StatReadyBit   = 7;
    localparam int unsigned StatOverrunBit = 6;

endpackage

// File: rtl/in_port_2_serial_shift_in.sv
// Serial-to-parallel front end of the SAP-II input port.
// Assembles LSB-first words one bit per shift strobe.
// Ports:
//   CLK, CLR_n  clock, asynchronous active-low reset
//   serial_in   serial data bit
//   shift_in    bit strobe, one bit captured per cycle while high
//   sync        drops any partial word (wins over shift_in)
//   bitcnt      bits received so far in the current word
//   done        combinational: this cycle's strobe completes a word
//   word        combinational: the completed word (valid when done=1)
module in_port_2_serial_shift_in
    import in_port_2_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
    input  logic              CLK,
    input  logic              CLR_n,
    input  logic              serial_in,
    input  logic              shift_in,
    input  logic              sync,
    output logic [CNT_W-1:0]  bitcnt,
    output logic              done,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              unused_lsb;

    // The oldest bit falls off the bottom once the word is full; it is never needed.
    assign unused_lsb = shreg_q[0];

    assign word   = {serial_in, shreg_q[DATA_W-1:1]};
    assign done   = shift_in && !sync && (bitcnt_q == CNT_W'(DATA_W - 1));
    assign bitcnt = bitcnt_q;

    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        if (sync) begin
            shreg_d  = '0;
            bitcnt_d = '0;
        end else if (shift_in) begin
            shreg_d  = word;
            // Explicit wrap keeps non-power-of-two widths correct.
            bitcnt_d = done ? '0 : bitcnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

endmodule

// File: rtl/in_port_2.sv
// SAP-II serial input port.
// Receives LSB-first words, holds the last accepted word with a READY/OVERRUN handshake,
// and drives the data or status byte onto the shared WBUS.
// Ports:
//   CLK, CLR_n   clock, asynchronous active-low reset
//   serial_in    serial data bit
//   shift_in     bit strobe
//   sync         resynchronise, discards any partial word
//   Ei2          drive data byte onto WBUS; the edge consumes it (clears ready)
//   Es2          drive status byte onto WBUS; the edge clears overrun (Ei2 has priority)
//   WBUS         tri-state bus, high-Z unless Ei2 or Es2 is high
//   ready        an unread word is held
//   overrun      sticky: a completed word was dropped
//   acknowledge  one-cycle pulse after a word is accepted
module in_port_2
    import in_port_2_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              CLK,
    input  logic              CLR_n,
    input  logic              serial_in,
    input  logic              shift_in,
    input  logic              sync,
    input  logic              Ei2,
    input  logic              Es2,
    output wire  [DATA_W-1:0] WBUS,
    output logic              ready,
    output logic              overrun,
    output logic              acknowledge
);

    localparam int unsigned CNT_W      = $clog2(DATA_W);
    localparam int unsigned ReadyPos   = DATA_W - DataWDefault + StatReadyBit;
    localparam int unsigned OverrunPos = DATA_W - DataWDefault + StatOverrunBit;

    logic [CNT_W-1:0]  bitcnt;
    logic              done;
    logic [DATA_W-1:0] word;
    logic              accept;
    logic [DATA_W-1:0] status;

    logic [DATA_W-1:0] data_reg_q, data_reg_d;
    logic              ready_q, ready_d;
    logic              overrun_q, overrun_d;
    logic              ack_q, ack_d;

    in_port_2_serial_shift_in #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_serial_shift_in (
        .CLK       (CLK),
        .CLR_n     (CLR_n),
        .serial_in (serial_in),
        .shift_in  (shift_in),
        .sync      (sync),
        .bitcnt    (bitcnt),
        .done      (done),
        .word      (word)
    );

    // A read on the completing edge frees the register, so the new word is taken.
    assign accept = done && (!ready_q || Ei2);

    always_comb begin
        data_reg_d = data_reg_q;
        ready_d    = ready_q;
        overrun_d  = overrun_q;
        ack_d      = accept;

        if (accept) begin
            data_reg_d = word;
            ready_d    = 1'b1;
        end else if (Ei2) begin
            ready_d    = 1'b0;
        end

        if (done && !accept) begin
            overrun_d = 1'b1;
        end else if (Es2 && !Ei2) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            data_reg_q <= '0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            data_reg_q <= data_reg_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        status                = '0;
        status[CNT_W-1:0]     = bitcnt;
        status[ReadyPos]      = ready_q;
        status[OverrunPos]    = overrun_q;
    end

    assign WBUS = Ei2 ? data_reg_q : (Es2 ? status : {DATA_W{1'bz}});

    assign ready       = ready_q;
    assign overrun     = overrun_q;
    assign acknowledge = ack_q;

endmodule

// File: tb/tb_in_port_2.sv
// Directed self-checking bench for in_port_2 (DATA_W = 8).
// Inputs change on the falling clock edge; registered outputs are sampled there too,
// and combinational WBUS values are sampled 1 ns after an input change.
module tb_in_port_2;

    logic       CLK;
    logic       CLR_n;
    logic       serial_in;
    logic       shift_in;
    logic       sync;
    logic       Ei2;
    logic       Es2;
    tri0  [7:0] WBUS;
    logic       ready;
    logic       overrun;
    logic       acknowledge;

    int checks;
    int failures;

    in_port_2 #(
        .DATA_W (8)
    ) dut (
        .CLK         (CLK),
        .CLR_n       (CLR_n),
        .serial_in   (serial_in),
        .shift_in    (shift_in),
        .sync        (sync),
        .Ei2         (Ei2),
        .Es2         (Es2),
        .WBUS        (WBUS),
        .ready       (ready),
        .overrun     (overrun),
        .acknowledge (acknowledge)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shifts a full byte LSB-first, one strobe per cycle. When rd_last is set, Ei2 is held
    // during the final strobe. Returns at the falling edge after the completing edge.
    task automatic send_byte(input logic [7:0] b, input logic rd_last);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            shift_in  = 1'b1;
            Ei2       = rd_last && (i == 7);
            @(negedge CLK);
        end
        shift_in = 1'b0;
        Ei2      = 1'b0;
    endtask

    // Look at WBUS with the given enables without letting a clock edge see them.
    task automatic peek(input string tag, input logic ei, input logic es, input logic [7:0] exp);
        Ei2 = ei;
        Es2 = es;
        #1;
        check_eq(tag, WBUS, exp);
        Ei2 = 1'b0;
        Es2 = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        CLR_n     = 1'b0;
        serial_in = 1'b0;
        shift_in  = 1'b0;
        sync      = 1'b0;
        Ei2       = 1'b0;
        Es2       = 1'b0;

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_ack", acknowledge, 0);
        check_eq("rst_wbus_released", WBUS, 8'h00);
        CLR_n = 1'b1;
        @(negedge CLK);

        // Basic receive: bits 1,0,1,0,1,1,0,0 -> 8'h35
        send_byte(8'h35, 1'b0);
        check_eq("t1_ready", ready, 1);
        check_eq("t1_ack", acknowledge, 1);
        check_eq("t1_wbus_released", WBUS, 8'h00);
        Ei2 = 1'b1;
        #1;
        check_eq("t1_data", WBUS, 8'h35);
        @(negedge CLK);
        Ei2 = 1'b0;
        check_eq("t1_ack_one_cycle", acknowledge, 0);
        check_eq("t1_ready_cleared", ready, 0);

        // Overrun: 8'h25 kept, 8'h45 dropped
        send_byte(8'h25, 1'b0);
        check_eq("t2_ack_first", acknowledge, 1);
        send_byte(8'h45, 1'b0);
        check_eq("t2_overrun", overrun, 1);
        check_eq("t2_no_second_ack", acknowledge, 0);
        check_eq("t2_ready", ready, 1);
        peek("t2_data_kept", 1'b1, 1'b0, 8'h25);
        Es2 = 1'b1;
        #1;
        check_eq("t2_status_c0", WBUS, 8'hC0);
        @(negedge CLK);
        #1;
        check_eq("t2_status_80", WBUS, 8'h80);
        check_eq("t2_overrun_cleared", overrun, 0);
        @(negedge CLK);
        Es2 = 1'b0;
        Ei2 = 1'b1;
        #1;
        check_eq("t2_data_read", WBUS, 8'h25);
        @(negedge CLK);
        Ei2 = 1'b0;
        check_eq("t2_ready_cleared", ready, 0);

        // Completion on the same edge as a data read
        send_byte(8'h11, 1'b0);
        check_eq("t3_ready_held", ready, 1);
        send_byte(8'h55, 1'b1);
        check_eq("t3_ready_stays", ready, 1);
        check_eq("t3_ack", acknowledge, 1);
        check_eq("t3_no_overrun", overrun, 0);
        Ei2 = 1'b1;
        #1;
        check_eq("t3_data_55", WBUS, 8'h55);
        @(negedge CLK);
        Ei2 = 1'b0;
        check_eq("t3_ready_cleared", ready, 0);

        // Resynchronise after 3 bits; the 4th strobe is discarded
        for (int i = 0; i < 3; i++) begin
            serial_in = 1'b1;
            shift_in  = 1'b1;
            @(negedge CLK);
        end
        shift_in = 1'b0;
        peek("t4_status_bitcnt3", 1'b0, 1'b1, 8'h03);
        serial_in = 1'b1;
        shift_in  = 1'b1;
        sync      = 1'b1;
        @(negedge CLK);
        shift_in = 1'b0;
        sync     = 1'b0;
        peek("t4_status_after_sync", 1'b0, 1'b1, 8'h00);
        send_byte(8'h65, 1'b0);
        check_eq("t4_ready", ready, 1);
        peek("t4_data_65", 1'b1, 1'b0, 8'h65);

        // Reset mid-word with ready=1
        send_byte(8'hA5, 1'b0);
        check_eq("t5_overrun_before_rst", overrun, 1);
        for (int i = 0; i < 5; i++) begin
            serial_in = 1'b1;
            shift_in  = 1'b1;
            @(negedge CLK);
        end
        shift_in = 1'b0;
        #2;
        CLR_n = 1'b0;
        #1;
        check_eq("t5_rst_ready", ready, 0);
        check_eq("t5_rst_overrun", overrun, 0);
        check_eq("t5_rst_ack", acknowledge, 0);
        check_eq("t5_rst_wbus_released", WBUS, 8'h00);
        @(negedge CLK);
        CLR_n = 1'b1;
        peek("t5_status_after_rst", 1'b0, 1'b1, 8'h00);
        send_byte(8'h85, 1'b0);
        check_eq("t5_ready", ready, 1);
        check_eq("t5_ack", acknowledge, 1);
        peek("t5_data_85", 1'b1, 1'b0, 8'h85);

        // Ei2 and Es2 together with overrun pending
        send_byte(8'h3C, 1'b0);
        check_eq("t6_overrun", overrun, 1);
        Ei2 = 1'b1;
        Es2 = 1'b1;
        #1;
        check_eq("t6_data_priority", WBUS, 8'h85);
        @(negedge CLK);
        Ei2 = 1'b0;
        Es2 = 1'b0;
        check_eq("t6_overrun_kept", overrun, 1);
        check_eq("t6_ready_cleared", ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/in_port_2.md
# in_port_2

Serial input port for the SAP-II I/O section. It assembles bytes arriving LSB-first on a serial line, paced by a per-bit shift strobe. This matches the bit order the accumulator output port emits on its SERIAL OUT pin. Completed bytes are held in a data register with a READY/OVERRUN handshake, and the CPU reads the data byte or a status byte onto the WBUS through tri-state enables.

## Interface
- `DATA_W`, default 8: serial word width in bits. The bit counter is sized as clog2(DATA_W).
- `CLK`  in  1  system clock. All state changes on its rising edge.
- `CLR_n`  in  1  reset, asynchronous, active-low.
- `serial_in`  in  1  serial data bit, sampled on `CLK` when `shift_in`=1.
- `shift_in`  in  1  bit strobe. One bit is captured per cycle while it is high.
- `sync`  in  1  resynchronise. Discards any partial word.
- `Ei2`  in  1  enable data byte onto `WBUS`.
- `Es2`  in  1  enable status byte onto `WBUS`.
- `WBUS`  out  DATA_W  tri-state bus driver, high-Z unless `Ei2` or `Es2` is high.
- `ready`  out  1  an unread byte is held.
- `overrun`  out  1  sticky flag: a byte was dropped.
- `acknowledge`  out  1  one-cycle pulse when a completed byte is accepted into the data register.

## Operation
- Registers:
  - `shreg[DATA_W-1:0]`
  - `bitcnt`
  - `data_reg`
  - `ready`
  - `overrun`
  - `acknowledge`
- Values on `CLR_n`=0: all registers are 0, `WBUS` is high-Z.
- Shift rule, when `shift_in`=1 and `sync`=0: `shreg` <= {serial_in, shreg[DATA_W-1:1]} and `bitcnt` <= `bitcnt`+1. The first received bit ends up in bit 0.
- Word completion happens on the strobe where `bitcnt`==DATA_W-1:
  - Accept case, when `ready`=0 or a data read (`Ei2`) occurs in the same cycle:
    - `data_reg` <= {serial_in, shreg[DATA_W-1:1]}
    - `ready` <= 1
    - `acknowledge` <= 1 for one cycle
  - Drop case, when `ready`=1 and no `Ei2` read occurs:
    - `data_reg` keeps the old byte
    - `overrun` <= 1
    - no acknowledge pulse
  - In both cases `bitcnt` wraps to 0.
- `sync`=1: `bitcnt` <= 0 and `shreg` <= 0. `sync` wins over a simultaneous `shift_in`, and that bit is discarded. `ready`, `data_reg` and `overrun` are unaffected.
- Data read: while `Ei2`=1, `WBUS` = `data_reg` combinationally. At the clock edge with `Ei2`=1, `ready` <= 0, unless a completion is accepted on the same edge, in which case `ready` stays 1.
- Status read: while `Es2`=1 and `Ei2`=0, `WBUS` = {ready, overrun, zero pad, bitcnt}. `bitcnt` occupies the low bits and zeros fill the middle. At that clock edge, `overrun` <= 0. A new overrun on the same edge wins and `overrun` stays 1.
- `Ei2` and `Es2` both high: `Ei2` has priority. Only the data byte is driven and `overrun` is not cleared.

## Timing
- Latency from the last strobe edge to `ready`=1 and valid `data_reg`: the same edge, with outputs visible in the following cycle.
- Back-to-back strobes are legal every cycle. A full word takes a minimum of DATA_W cycles.
- `acknowledge` is high for exactly the cycle after an accepting edge.
- `WBUS` drive is purely combinational from `Ei2`/`Es2` and has no register stage.
- Reset mid-word: asserting `CLR_n` low immediately drops the partial word and all flags, and `WBUS` goes high-Z. The first strobe after release counts as bit 0.

## Structure
- Shared SAP-II package holds:
  - the status-byte bit positions (READY=7, OVERRUN=6)
  - the `DATA_W` default
- One sub-module, `serial_shift_in`: contains `shreg` and `bitcnt`, and outputs the completion strobe and the assembled word.
- The top level holds:
  - the data register
  - the handshake flags
  - the bus drivers

## Test plan
- Reset, then 8 consecutive strobes with `serial_in` = 1,0,1,0,1,1,0,0 -> `ready`=1, one-cycle `acknowledge`, and `Ei2` gives `WBUS`=8'h35. After the read edge, `ready`=0.
- Receive 8'h25 and do not read, then receive 8'h45 -> `overrun`=1, no second `acknowledge`, and `Ei2` still gives 8'h25. A later `Es2` read returns 8'hC0, then the following `Es2` read returns 8'h80 (overrun cleared on the previous edge). A subsequent `Ei2` read then clears `ready`.
- Hold `ready`=1, then complete a new byte 8'h55 on the same edge as an `Ei2` read -> `ready` stays 1, `acknowledge` pulses, `overrun`=0, and the next read gives 8'h55.
- Send 3 bits, assert `sync` together with a 4th strobe, then send 8'h65 -> `data_reg`=8'h65. The `Es2` read before completion shows `bitcnt`=0 right after `sync`.
- Pull `CLR_n` low after 5 bits while `ready`=1 -> all outputs are 0 and `WBUS` is high-Z immediately. After release, 8'h85 is received correctly.
- `Ei2` and `Es2` both high with `overrun`=1 -> `WBUS`=`data_reg` and `overrun` remains 1.
